// File: rtl/fsm_traffic_light_nway_if.sv
// Signal bundle between the N-way traffic-light controller and its environment.
// The master side drives demand and parade requests; the slave (controller) drives the lamps.
interface fsm_traffic_light_nway_if #(
    parameter int N_DIR = 3,
    parameter int PTR_W = $clog2(N_DIR)
);
    logic [N_DIR-1:0]   i_traffic;
    logic               i_park;
    logic               i_release;
    logic [2*N_DIR-1:0] o_light;
    logic [PTR_W-1:0]   o_active;
    logic               o_park;
    // Phase register exposed for checkers: 0 GREEN, 1 YELLOW, 2 ALLRED.
    logic [1:0]         o_dbg_phase;

    modport master (
        output i_traffic,
        output i_park,
        output i_release,
        input  o_light,
        input  o_active,
        input  o_park,
        input  o_dbg_phase
    );

    modport slave (
        input  i_traffic,
        input  i_park,
        input  i_release,
        output o_light,
        output o_active,
        output o_park,
        output o_dbg_phase
    );
endinterface

// File: rtl/fsm_traffic_light_nway.sv
// Round-robin N-direction traffic-light controller with minimum-green, yellow and parade hold.
// Optional macro FSM_TL_ALL_RED_EN inserts an all-red clearance phase after every yellow.
module fsm_traffic_light_nway #(
    parameter int N_DIR         = 3,
    parameter int MIN_GREEN_CYC = 8,
    parameter int YELLOW_CYC    = 3,
    parameter int ALLRED_CYC    = 2,
    parameter int PARADE_DIR    = 1,
    parameter int CNT_W         = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rstn,
    fsm_traffic_light_nway_if.slave     bus
);

    localparam int PTR_W = $clog2(N_DIR);
    localparam int N_PAD = 1 << PTR_W;

    localparam logic [PTR_W-1:0] LAST_DIR    = PTR_W'(N_DIR - 1);
    localparam logic [PTR_W-1:0] PARADE_PTR  = PTR_W'(PARADE_DIR);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(MIN_GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
`ifdef FSM_TL_ALL_RED_EN
    localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_CYC - 1);
`endif

    localparam logic [1:0] LAMP_GREEN  = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_RED    = 2'd2;

`ifdef FSM_TL_ALL_RED_EN
    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2
    } phase_e;
`else
    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1
    } phase_e;
`endif

    typedef enum logic {
        PK_IDLE   = 1'b0,
        PK_PARADE = 1'b1
    } park_e;

    phase_e            phase_q, phase_d;
    park_e             park_q, park_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  timer_q, timer_d;

    logic [CNT_W-1:0]  timer_inc;
    logic [PTR_W-1:0]  ptr_next;
    logic [N_PAD-1:0]  traffic_pad;
    logic              parade_hold;
    logic              green_done;
    logic [2*N_DIR-1:0] light;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            phase_q <= PH_GREEN;
            park_q  <= PK_IDLE;
            ptr_q   <= '0;
            timer_q <= '0;
        end else begin
            phase_q <= phase_d;
            park_q  <= park_d;
            ptr_q   <= ptr_d;
            timer_q <= timer_d;
        end
    end

    // Parade FSM: with both requests high the current state decides which one wins.
    always_comb begin
        park_d = park_q;
        case (park_q)
            PK_IDLE:   if (bus.i_park)    park_d = PK_PARADE;
            PK_PARADE: if (bus.i_release) park_d = PK_IDLE;
            default:   park_d = PK_IDLE;
        endcase
    end

    // Padding lets ptr_q index demand safely even when N_DIR is not a power of two.
    always_comb begin
        traffic_pad              = '0;
        traffic_pad[N_DIR-1:0]   = bus.i_traffic;
    end

    assign timer_inc   = (timer_q == {CNT_W{1'b1}}) ? timer_q : timer_q + CNT_W'(1);
    assign ptr_next    = (ptr_q == LAST_DIR) ? '0 : ptr_q + PTR_W'(1);
    assign parade_hold = (park_q == PK_PARADE) && (ptr_q == PARADE_PTR);
    assign green_done  = (timer_q >= GREEN_LAST) && !traffic_pad[ptr_q] && !parade_hold;

    always_comb begin
        phase_d = phase_q;
        ptr_d   = ptr_q;
        timer_d = timer_inc;
        case (phase_q)
            PH_GREEN: begin
                if (green_done) begin
                    phase_d = PH_YELLOW;
                    timer_d = '0;
                end
            end
            PH_YELLOW: begin
                if (timer_q == YELLOW_LAST) begin
`ifdef FSM_TL_ALL_RED_EN
                    phase_d = PH_ALLRED;
`else
                    phase_d = PH_GREEN;
                    ptr_d   = ptr_next;
`endif
                    timer_d = '0;
                end
            end
`ifdef FSM_TL_ALL_RED_EN
            PH_ALLRED: begin
                if (timer_q == ALLRED_LAST) begin
                    phase_d = PH_GREEN;
                    ptr_d   = ptr_next;
                    timer_d = '0;
                end
            end
`endif
            default: begin
                phase_d = PH_GREEN;
                ptr_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    function automatic logic [1:0] lamp_code(input phase_e ph);
        case (ph)
            PH_GREEN:  lamp_code = LAMP_GREEN;
            PH_YELLOW: lamp_code = LAMP_YELLOW;
            default:   lamp_code = LAMP_RED;
        endcase
    endfunction

    // Only the direction at ptr_q can ever show a non-RED code.
    always_comb begin
        light = '0;
        for (int d = 0; d < N_DIR; d++) begin
            light[2*d +: 2] = (ptr_q == PTR_W'(d)) ? lamp_code(phase_q) : LAMP_RED;
        end
    end

    assign bus.o_light     = light;
    assign bus.o_active    = ptr_q;
    assign bus.o_park      = (park_q == PK_PARADE);
    assign bus.o_dbg_phase = phase_q;

endmodule

// File: tb/tb_fsm_traffic_light_nway.sv
// Directed bench for fsm_traffic_light_nway (N_DIR=3, MIN_GREEN=8, YELLOW=3, ALLRED=2, PARADE_DIR=1).
// Follows FSM_TL_ALL_RED_EN so the same sequence covers both builds.
module tb_fsm_traffic_light_nway;

`ifdef FSM_TL_ALL_RED_EN
    localparam int AR = 2;
`else
    localparam int AR = 0;
`endif

    localparam logic [5:0] L_G0 = 6'b10_10_00;
    localparam logic [5:0] L_Y0 = 6'b10_10_01;
    localparam logic [5:0] L_G1 = 6'b10_00_10;
    localparam logic [5:0] L_Y1 = 6'b10_01_10;
    localparam logic [5:0] L_G2 = 6'b00_10_10;
    localparam logic [5:0] L_Y2 = 6'b01_10_10;
`ifdef FSM_TL_ALL_RED_EN
    localparam logic [5:0] L_AR = 6'b10_10_10;
`endif

    logic clk;
    logic rstn;
    int   total;
    int   bad;
    int   cyc;

    fsm_traffic_light_nway_if #(.N_DIR(3)) bus ();

    fsm_traffic_light_nway #(
        .N_DIR(3), .MIN_GREEN_CYC(8), .YELLOW_CYC(3),
        .ALLRED_CYC(2), .PARADE_DIR(1), .CNT_W(8)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc  = 0;
    endtask

    task automatic chk_p(input string tag, input logic exp_p);
        total++;
        assert (bus.o_park === exp_p) else begin
            bad++;
            $error("FAIL %s park got=%b exp=%b", tag, bus.o_park, exp_p);
        end
    endtask

    task automatic chk(input string tag, input logic [5:0] exp_l,
                       input logic [1:0] exp_a, input logic exp_p);
        total++;
        assert (bus.o_light === exp_l) else begin
            bad++;
            $error("FAIL %s light got=%b exp=%b", tag, bus.o_light, exp_l);
        end
        total++;
        assert (bus.o_active === exp_a) else begin
            bad++;
            $error("FAIL %s active got=%0d exp=%0d", tag, bus.o_active, exp_a);
        end
        chk_p(tag, exp_p);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        cyc           = 0;
        rstn          = 1'b0;
        bus.i_traffic = 3'b001;
        bus.i_park    = 1'b0;
        bus.i_release = 1'b0;

        // Demand on dir0 holds its green; dropping it ends green on the same edge.
        do_reset();
        chk("t1_reset", L_G0, 2'd0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            adv_to(10 * k);
            chk("t1_hold", L_G0, 2'd0, 1'b0);
        end
        bus.i_traffic = 3'b000;
        step();
        chk("t1_drop_yellow", L_Y0, 2'd0, 1'b0);

        // Full round: green 8, yellow 3, optional all-red, then wrap to dir0.
        do_reset();
        chk("t2_c0", L_G0, 2'd0, 1'b0);
        adv_to(7);       chk("t2_g0_last", L_G0, 2'd0, 1'b0);
        adv_to(8);       chk("t2_y0_first", L_Y0, 2'd0, 1'b0);
        adv_to(10);      chk("t2_y0_last", L_Y0, 2'd0, 1'b0);
`ifdef FSM_TL_ALL_RED_EN
        adv_to(11);      chk("t2_ar0_a", L_AR, 2'd0, 1'b0);
        adv_to(12);      chk("t2_ar0_b", L_AR, 2'd0, 1'b0);
`endif
        adv_to(11 + AR); chk("t2_g1_first", L_G1, 2'd1, 1'b0);
        adv_to(18 + AR); chk("t3_g1_last", L_G1, 2'd1, 1'b0);
        adv_to(19 + AR); chk("t3_y1_first", L_Y1, 2'd1, 1'b0);
        adv_to(21 + AR); chk("t3_y1_last", L_Y1, 2'd1, 1'b0);
        adv_to(22 + 2*AR); chk("t3_g2_first", L_G2, 2'd2, 1'b0);
        adv_to(29 + 2*AR); chk("t3_g2_last", L_G2, 2'd2, 1'b0);
        adv_to(30 + 2*AR); chk("t3_y2_first", L_Y2, 2'd2, 1'b0);
        adv_to(32 + 2*AR); chk("t3_y2_last", L_Y2, 2'd2, 1'b0);
`ifdef FSM_TL_ALL_RED_EN
        adv_to(33 + 2*AR); chk("t3_ar2_a", L_AR, 2'd2, 1'b0);
        adv_to(34 + 2*AR); chk("t3_ar2_b", L_AR, 2'd2, 1'b0);
`endif
        adv_to(33 + 3*AR); chk("t3_wrap_g0", L_G0, 2'd0, 1'b0);

        // Parade: dir1 held green past timer saturation, released 2 edges after pulse.
        do_reset();
        adv_to(11 + AR);
        chk("t4_g1_start", L_G1, 2'd1, 1'b0);
        bus.i_park = 1'b1;
        step();
        bus.i_park = 1'b0;
        chk("t4_park_set", L_G1, 2'd1, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            adv_to(11 + AR + 20 * k);
            chk("t4_hold", L_G1, 2'd1, 1'b1);
        end
        adv_to(11 + AR + 257);
        chk("t4_pre_release", L_G1, 2'd1, 1'b1);
        bus.i_release = 1'b1;
        step();
        bus.i_release = 1'b0;
        chk("t4_release_edge1", L_G1, 2'd1, 1'b0);
        step();
        chk("t4_release_edge2", L_Y1, 2'd1, 1'b0);

        // Simultaneous park and release toggles the mode each time.
        bus.i_park    = 1'b1;
        bus.i_release = 1'b1;
        step();
        chk_p("t5_both_from_idle", 1'b1);
        step();
        bus.i_park    = 1'b0;
        bus.i_release = 1'b0;
        chk_p("t5_both_from_parade", 1'b0);

        // Reset in the middle of dir2 yellow, with parade flag set.
        do_reset();
        adv_to(22 + 2*AR);
        chk("t6_g2", L_G2, 2'd2, 1'b0);
        bus.i_park = 1'b1;
        step();
        bus.i_park = 1'b0;
        chk("t6_park_on_g2", L_G2, 2'd2, 1'b1);
        adv_to(31 + 2*AR);
        chk("t6_mid_y2", L_Y2, 2'd2, 1'b1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("t6_after_reset", L_G0, 2'd0, 1'b0);
        step();
        chk("t6_post_reset_run", L_G0, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
